// File: rtl/hex_display_scanner.sv
// Multi-digit hex display driver. It outputs static per-digit 7-seg codes and a guarded
// time-multiplexed seg/anode scan. Values come from shadow registers captured on Load.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 1024,
  parameter int GUARD       = 2,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   Dp_In,
  input  logic                    Load,
  input  logic                    Lz_En,
  output logic [7*NUM_DIGITS-1:0] Hex_Out,
  output logic [6:0]              Seg,
  output logic                    Dp,
  output logic [NUM_DIGITS-1:0]   Anode,
  output logic [IDX_W-1:0]        Digit_Idx
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? '1 : '0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] lo;
    case (nib)
      4'h0: lo = 7'h40;  4'h1: lo = 7'h79;  4'h2: lo = 7'h24;  4'h3: lo = 7'h30;
      4'h4: lo = 7'h19;  4'h5: lo = 7'h12;  4'h6: lo = 7'h02;  4'h7: lo = 7'h78;
      4'h8: lo = 7'h00;  4'h9: lo = 7'h10;  4'hA: lo = 7'h08;  4'hB: lo = 7'h03;
      4'hC: lo = 7'h46;  4'hD: lo = 7'h21;  4'hE: lo = 7'h06;  default: lo = 7'h0E;
    endcase
    return (SEG_ACT_LOW != 0) ? lo : ~lo;
  endfunction

  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [6:0]              seg_q;
  logic                    dp_out_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    upper_zero;

  // Scan from the top digit downward so "this digit and everything above is zero" is a running AND
  always_comb begin
    hex_d      = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero & (val_q[4*k +: 4] == 4'h0);
      if (Lz_En && (k > 0) && upper_zero)
        hex_d[7*k +: 7] = SEG_OFF;
      else
        hex_d[7*k +: 7] = hex_to_seg(val_q[4*k +: 4]);
    end
  end

  // Anode is derived from the next counter state so it lines up with the registered counter
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    if (int'(cnt_d) < GUARD)
      an_d = AN_OFF;
    else
      an_d = (NUM_DIGITS'(1) << idx_d) ^ AN_OFF;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      val_q    <= '0;
      dp_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      hex_q    <= {NUM_DIGITS{SEG_OFF}};
      seg_q    <= SEG_OFF;
      dp_out_q <= DP_OFF;
      an_q     <= AN_OFF;
    end else begin
      if (Load) begin
        val_q <= Value;
        dp_q  <= Dp_In;
      end
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hex_q    <= hex_d;
      seg_q    <= hex_d[7*int'(idx_q) +: 7];
      dp_out_q <= dp_q[idx_q] ^ DP_OFF;
      an_q     <= an_d;
    end
  end

  assign Hex_Out   = hex_q;
  assign Seg       = seg_q;
  assign Dp        = dp_out_q;
  assign Anode     = an_q;
  assign Digit_Idx = idx_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: load responses are queued with their due edge,
// and a monitor compares static and scanned outputs against a reference model every cycle.
module tb_hex_display_scanner;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GD = 2;

  localparam logic [6:0] HEX_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [15:0] Value = '0;
  logic [3:0]  Dp_In = '0;
  logic        Load = 1'b0;
  logic        Lz_En = 1'b0;
  logic [27:0] Hex_Out;
  logic [6:0]  Seg;
  logic        Dp;
  logic [3:0]  Anode;
  logic [1:0]  Digit_Idx;

  hex_display_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD),
                        .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Value(Value), .Dp_In(Dp_In), .Load(Load), .Lz_En(Lz_En),
    .Hex_Out(Hex_Out), .Seg(Seg), .Dp(Dp), .Anode(Anode), .Digit_Idx(Digit_Idx)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    logic [27:0] hex;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ecnt = 0;
  int          last_evt = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lz = 1'b0;

  // Edges counted since reset release; the scan position is a pure function of this count
  always @(posedge Clk or negedge Reset_n)
    if (!Reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;

  function automatic logic [6:0] m_code(input logic [15:0] v, input logic lz, input int k);
    logic [3:0] nib;
    nib = 4'((v >> (4 * k)) & 16'hF);
    if (lz && k > 0 && (v >> (4 * k)) == 16'h0) return 7'h7F;
    return HEX_TAB[nib];
  endfunction

  function automatic logic [27:0] m_hex(input logic [15:0] v, input logic lz);
    logic [27:0] r;
    r = '0;
    for (int k = 0; k < ND; k++) r = r | (28'(m_code(v, lz, k)) << (7 * k));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  int          mon_ph, mon_slot;
  logic [3:0]  mon_an;
  exp_t        mon_ex;

  always @(negedge Clk) begin
    if (Reset_n) begin
      mon_ph   = ecnt % SD;
      mon_slot = (ecnt / SD) % ND;
      mon_an   = (mon_ph < GD) ? 4'hF : ~(4'b0001 << mon_slot);
      check("digit_idx", 32'(Digit_Idx), 32'(mon_slot));
      check("anode", 32'(Anode), 32'(mon_an));
      while (q.size() > 0 && q[0].due <= ecnt) begin
        mon_ex = q.pop_front();
        check("hex_load", 32'(Hex_Out), 32'(mon_ex.hex));
      end
      if (ecnt >= last_evt + 2) begin
        check("hex_stable", 32'(Hex_Out), 32'(m_hex(m_val, m_lz)));
        if (mon_ph >= GD) begin
          check("seg", 32'(Seg), 32'(m_code(m_val, m_lz, mon_slot)));
          check("dp", 32'(Dp), 32'(!m_dp[mon_slot]));
        end
      end
    end
  end

  // Load is sampled at edge N = ecnt+1; Hex_Out holds the old code at N and the new one at N+1
  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    @(posedge Clk); #1;
    q.push_back('{due: ecnt + 1, hex: m_hex(m_val, lz)});
    q.push_back('{due: ecnt + 2, hex: m_hex(v, lz)});
    Value = v; Dp_In = dp; Lz_En = lz; Load = 1'b1;
    m_val = v; m_dp = dp; m_lz = lz;
    last_evt = ecnt + 1;
    @(posedge Clk); #1;
    Load = 1'b0;
  endtask

  task automatic set_lz(input logic lz);
    @(posedge Clk); #1;
    Lz_En = lz; m_lz = lz;
    last_evt = ecnt + 1;
  endtask

  task automatic do_reset();
    @(negedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    check("rst_anode", 32'(Anode), 32'h0000000F);
    check("rst_seg", 32'(Seg), 32'h0000007F);
    check("rst_dp", 32'(Dp), 32'h00000001);
    check("rst_hex", 32'(Hex_Out), 32'h0FFFFFFF);
    check("rst_idx", 32'(Digit_Idx), 32'h00000000);
    q.delete();
    m_val = '0; m_dp = '0; last_evt = 0; Load = 1'b0;
    @(negedge Clk); #2;
    Reset_n = 1'b1;
  endtask

  task automatic random_ops(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0, 1: do_load(16'($urandom) >> $urandom_range(0, 16), 4'($urandom), 1'($urandom_range(0, 1)));
        2: begin
          @(posedge Clk); #1;
          Value = 16'($urandom); Dp_In = 4'($urandom);
        end
        default: set_lz(1'($urandom_range(0, 1)));
      endcase
      repeat ($urandom_range(1, 20)) @(posedge Clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();
    repeat (3) @(posedge Clk);

    do_load(16'h1A3F, 4'h0, 1'b0);
    q.push_back('{due: ecnt + 1, hex: {7'h79, 7'h08, 7'h30, 7'h0E}});
    repeat (4) @(posedge Clk);
    #1 Value = 16'h5555; Dp_In = 4'hF;
    repeat (10) @(posedge Clk);

    do_load(16'h0050, 4'h0, 1'b1);
    q.push_back('{due: ecnt + 1, hex: {7'h7F, 7'h7F, 7'h12, 7'h40}});
    repeat (3) @(posedge Clk);
    do_load(16'h0000, 4'h0, 1'b1);
    q.push_back('{due: ecnt + 1, hex: {7'h7F, 7'h7F, 7'h7F, 7'h40}});
    repeat (3) @(posedge Clk);

    do_load(16'h1234, 4'b0100, 1'b0);
    repeat (40) @(posedge Clk);

    random_ops(40);
    do_reset();
    repeat (5) @(posedge Clk);
    random_ops(15);

    repeat (4) @(posedge Clk);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
